operand_packer: RTL and testbench

- Transmit-side front end for the four-operand adder: gathers four W-bit operands, one per beat, over a valid/ready input stream.
- Emits them, with a carry-in, as the packed {cin, w, z, y, x} operand bus the adder consumes.
- The packed bus is held in an output register with its own valid/ready handshake, so collection of the next group overlaps draining of the current one.

---
 rtl/operand_packer.sv | 109 ++++++++++
 tb/tb_operand_packer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_packer.sv
// rtl/operand_packer.sv - gathers four operand beats into a registered {cin, w, z, y, x} bus
module operand_packer #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*W:0]       ins,
  output logic [1:0]         beat_cnt,
  output logic [CNT_W-1:0]   group_cnt
);

  logic [1:0]       beat_q, beat_d;
  logic [W-1:0]     x_q, x_d;
  logic [W-1:0]     y_q, y_d;
  logic [W-1:0]     z_q, z_d;
  logic [4*W:0]     ins_q, ins_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] group_q, group_d;

  logic accept;
  logic last_beat;
  logic out_fire;

  // Beats 0-2 only touch staging, so they are always taken; the 4th beat needs
  // the output register to be free or draining this cycle.
  always_comb begin
    in_ready = 1'b0;
    if (!flush) begin
      in_ready = (beat_q != 2'd3) || !out_valid_q || out_ready;
    end
  end

  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (beat_q == 2'd3);
  assign out_fire  = out_valid_q && out_ready;

  // Next-state for staging, beat counter, output register and group counter.
  always_comb begin
    beat_d      = beat_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    ins_d       = ins_q;
    out_valid_d = out_valid_q;
    group_d     = group_q;

    if (flush) begin
      beat_d = 2'd0;
      x_d    = '0;
      y_d    = '0;
      z_d    = '0;
    end else if (accept) begin
      beat_d = beat_q + 2'd1;
      case (beat_q)
        2'd0:    x_d = in_data;
        2'd1:    y_d = in_data;
        2'd2:    z_d = in_data;
        default: ins_d = {in_cin, in_data, z_q, y_q, x_q};
      endcase
    end

    // A new group landing in the same cycle as a transfer keeps valid high,
    // giving bubble-free back-to-back output.
    if (last_beat) begin
      out_valid_d = 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (out_fire) begin
      group_d = group_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q      <= 2'd0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      ins_q       <= '0;
      out_valid_q <= 1'b0;
      group_q     <= '0;
    end else begin
      beat_q      <= beat_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      ins_q       <= ins_d;
      out_valid_q <= out_valid_d;
      group_q     <= group_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ins       = ins_q;
  assign beat_cnt  = beat_q;
  assign group_cnt = group_q;

endmodule

// File: tb/tb_operand_packer.sv
// tb/tb_operand_packer.sv - scoreboard bench for operand_packer
module tb_operand_packer;

  localparam int W     = 8;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [4*W:0]     ins;
  logic [1:0]       beat_cnt;
  logic [CNT_W-1:0] group_cnt;

  int checks   = 0;
  int failures = 0;

  logic [4*W:0]     sb_q[$];
  logic [CNT_W-1:0] exp_grp;
  logic             prev_stall;
  logic [4*W:0]     prev_ins;

  operand_packer #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ins       (ins),
    .beat_cnt  (beat_cnt),
    .group_cnt (group_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected bus on each output handshake, checks group count and stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_grp    = '0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", {63'd0, out_valid}, 64'd1);
        check("stall_ins_held", {31'd0, ins}, {31'd0, prev_ins});
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got 0x%0h expected none", ins);
        end else begin
          check("out_ins", {31'd0, ins}, {31'd0, sb_q.pop_front()});
        end
        check("group_cnt_at_xfer", {62'd0, group_cnt}, {62'd0, exp_grp});
        exp_grp = exp_grp + 2'd1;
      end
      prev_stall = out_valid && !out_ready;
      prev_ins   = ins;
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic c);
    int n;
    in_data  = d;
    in_cin   = c;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        checks++;
        failures++;
        $display("FAIL beat_timeout: got in_ready=0 expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  logic [4*W:0] wrap_ins [5];
  logic [1:0]   wrap_cnt [5];

  initial begin
    wrap_ins[0] = 33'h0_04030201; wrap_cnt[0] = 2'd1;
    wrap_ins[1] = 33'h1_08070605; wrap_cnt[1] = 2'd2;
    wrap_ins[2] = 33'h0_0C0B0A09; wrap_cnt[2] = 2'd3;
    wrap_ins[3] = 33'h1_100F0E0D; wrap_cnt[3] = 2'd0;
    wrap_ins[4] = 33'h0_14131211; wrap_cnt[4] = 2'd1;

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_ins", {31'd0, ins}, 64'd0);
    check("rst_beat_cnt", {62'd0, beat_cnt}, 64'd0);
    check("rst_group_cnt", {62'd0, group_cnt}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Basic pack
    out_ready = 1'b1;
    sb_q.push_back(33'h1_44332211);
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    send_beat(8'h44, 1'b1);
    check("basic_latency_valid", {63'd0, out_valid}, 64'd1);
    check("basic_latency_ins", {31'd0, ins}, 64'h1_44332211);
    wait_drain();
    check("basic_group_cnt", {62'd0, group_cnt}, 64'd1);

    // Output stall
    out_ready = 1'b0;
    sb_q.push_back(33'h0_0D0C0B0A);
    send_beat(8'h0A, 1'b0);
    send_beat(8'h0B, 1'b0);
    send_beat(8'h0C, 1'b0);
    send_beat(8'h0D, 1'b0);
    sb_q.push_back(33'h0_04030201);
    send_beat(8'h01, 1'b1);
    send_beat(8'h02, 1'b1);
    send_beat(8'h03, 1'b1);
    check("stall_beat_cnt", {62'd0, beat_cnt}, 64'd3);
    in_data  = 8'h04;
    in_cin   = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    check("stall_old_ins", {31'd0, ins}, 64'h0_0D0C0B0A);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("release_valid", {63'd0, out_valid}, 64'd1);
    check("release_ins", {31'd0, ins}, 64'h0_04030201);
    wait_drain();
    check("stall_group_cnt", {62'd0, group_cnt}, 64'd3);

    // Back-to-back
    sb_q.push_back(33'h0_04030201);
    sb_q.push_back(33'h0_08070605);
    for (int i = 1; i <= 8; i++) send_beat(i[7:0], 1'b0);
    wait_drain();
    check("b2b_group_cnt", {62'd0, group_cnt}, 64'd1);

    // Flush
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b0);
    in_data  = 8'hCC;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    check("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_beat_cnt", {62'd0, beat_cnt}, 64'd0);
    sb_q.push_back(33'h0_04030201);
    for (int i = 1; i <= 4; i++) send_beat(i[7:0], 1'b0);
    wait_drain();
    check("flush_group_cnt", {62'd0, group_cnt}, 64'd2);

    // Async reset mid-operation
    out_ready = 1'b0;
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    send_beat(8'h44, 1'b0);
    send_beat(8'h55, 1'b0);
    send_beat(8'h66, 1'b0);
    check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    check("pre_rst_beat_cnt", {62'd0, beat_cnt}, 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_ins", {31'd0, ins}, 64'd0);
    check("arst_beat_cnt", {62'd0, beat_cnt}, 64'd0);
    check("arst_group_cnt", {62'd0, group_cnt}, 64'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Fresh groups after reset, counter wraps at CNT_W=2
    for (int g = 0; g < 5; g++) begin
      sb_q.push_back(wrap_ins[g]);
      for (int b = 1; b <= 4; b++) begin
        logic [7:0] d;
        d = 8'(4 * g + b);
        send_beat(d, (b == 4) ? g[0] : 1'b0);
      end
      wait_drain();
      check("wrap_group_cnt", {62'd0, group_cnt}, {62'd0, wrap_cnt[g]});
    end

    repeat (3) @(posedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
